// File: rtl/hs32_irq_seq_if.sv
// Single-word memory initiator bus carrying the interrupt-frame pushes and pops of hs32_irq_seq.
interface hs32_irq_seq_if;
  logic        stb;
  logic        ack;
  logic [31:0] addr;
  logic [31:0] dtw;
  logic [31:0] dtr;
  logic        rw;

  modport master (output stb, addr, dtw, rw, input ack, dtr);
  modport slave  (input stb, addr, dtw, rw, output ack, dtr);
endinterface

// File: rtl/hs32_irq_seq.sv
// CPU-side interrupt entry/return sequencer: pushes PC/flags, redirects to the handler, pops on reti.
// Optional bus timeout enabled by defining HS32_IRQ_SEQ_TIMEOUT_EN.
module hs32_irq_seq #(
  parameter int MAX_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           intrq,
  input  logic [4:0]     vec,
  input  logic [31:0]    handler,
  input  logic           nmi,
  input  logic           ie,
  input  logic           boundary,
  input  logic           reti,
  input  logic [31:0]    pc_cur,
  input  logic [31:0]    flags_cur,
  input  logic [31:0]    sp_cur,
  output logic           take,
  output logic           busy,
  output logic           redirect,
  output logic [31:0]    new_pc,
  output logic [31:0]    new_sp,
  output logic [31:0]    new_flags,
  output logic           restore_flags,
  output logic [4:0]     cur_vec,
  output logic [2:0]     depth,
  hs32_irq_seq_if.master bus,
  output logic           bus_fault
);

  localparam logic [2:0] DEPTH_MAX = 3'(MAX_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_PC,
    PUSH_FL,
    JUMP,
    POP_FL,
    POP_PC,
    RET
  } state_t;

  state_t               state;
  logic [31:0]          hnd_l;
  logic [31:0]          pc_l;
  logic [31:0]          fl_l;
  logic [31:0]          sp_l;
  logic [4:0]           vec_l;
  logic                 nmi_l;
  logic [MAX_DEPTH-1:0] nmi_stk;
  logic                 acked;
  logic                 stb;
  logic                 rw;
  logic [31:0]          addr;
  logic [31:0]          dtw;
  logic                 nmi_active;
  logic                 accept;
  logic                 ret_req;
`ifdef HS32_IRQ_SEQ_TIMEOUT_EN
  logic [3:0]           tmo;
  logic                 fault;
`endif

  // Bit 0 of the NMI stack is the level currently executing; zeros shift in on pop.
  assign nmi_active = nmi_stk[0];
  assign accept     = boundary && intrq &&
                      (nmi ? (!nmi_active && depth < DEPTH_MAX) : (ie && depth == 3'd0));
  assign ret_req    = reti && depth != 3'd0;
  assign take       = (state == IDLE) && accept && !ret_req;
  assign busy       = (state != IDLE);

  assign bus.stb  = stb;
  assign bus.rw   = rw;
  assign bus.addr = addr;
  assign bus.dtw  = dtw;

`ifdef HS32_IRQ_SEQ_TIMEOUT_EN
  assign bus_fault = fault;
`else
  assign bus_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      redirect      <= 1'b0;
      new_pc        <= '0;
      new_sp        <= '0;
      new_flags     <= '0;
      restore_flags <= 1'b0;
      cur_vec       <= '0;
      depth         <= '0;
      nmi_stk       <= '0;
      hnd_l         <= '0;
      pc_l          <= '0;
      fl_l          <= '0;
      sp_l          <= '0;
      vec_l         <= '0;
      nmi_l         <= 1'b0;
      acked         <= 1'b0;
      stb           <= 1'b0;
      rw            <= 1'b0;
      addr          <= '0;
      dtw           <= '0;
`ifdef HS32_IRQ_SEQ_TIMEOUT_EN
      tmo           <= '0;
      fault         <= 1'b0;
`endif
    end else begin
      redirect      <= 1'b0;
      restore_flags <= 1'b0;
`ifdef HS32_IRQ_SEQ_TIMEOUT_EN
      fault         <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef HS32_IRQ_SEQ_TIMEOUT_EN
          tmo <= '0;
`endif
          acked <= 1'b0;
          // A pending return always wins over a simultaneous request.
          if (ret_req) begin
            sp_l  <= sp_cur;
            state <= POP_FL;
            stb   <= 1'b1;
            rw    <= 1'b0;
            addr  <= sp_cur;
          end else if (take) begin
            hnd_l <= handler;
            vec_l <= vec;
            nmi_l <= nmi;
            pc_l  <= pc_cur;
            fl_l  <= flags_cur;
            sp_l  <= sp_cur;
            state <= PUSH_PC;
            stb   <= 1'b1;
            rw    <= 1'b1;
            addr  <= sp_cur - 32'd4;
            dtw   <= pc_cur;
          end
        end

        PUSH_PC, PUSH_FL, POP_FL, POP_PC: begin
          // Each access is a strobe phase ending on ack, then one idle-strobe cycle.
          if (acked) begin
            acked <= 1'b0;
            case (state)
              PUSH_PC: begin
                state <= PUSH_FL;
                stb   <= 1'b1;
                addr  <= sp_l - 32'd8;
                dtw   <= fl_l;
              end
              PUSH_FL: begin
                state     <= JUMP;
                redirect  <= 1'b1;
                new_pc    <= hnd_l;
                new_sp    <= sp_l - 32'd8;
                new_flags <= '0;
                depth     <= depth + 3'd1;
                nmi_stk   <= {nmi_stk[MAX_DEPTH-2:0], nmi_l};
                cur_vec   <= vec_l;
              end
              POP_FL: begin
                state <= POP_PC;
                stb   <= 1'b1;
                addr  <= sp_l + 32'd4;
              end
              default: begin
                state         <= RET;
                redirect      <= 1'b1;
                new_pc        <= pc_l;
                new_flags     <= fl_l;
                restore_flags <= 1'b1;
                new_sp        <= sp_l + 32'd8;
                depth         <= depth - 3'd1;
                nmi_stk       <= {1'b0, nmi_stk[MAX_DEPTH-1:1]};
              end
            endcase
          end else if (bus.ack) begin
            stb   <= 1'b0;
            acked <= 1'b1;
`ifdef HS32_IRQ_SEQ_TIMEOUT_EN
            tmo   <= '0;
`endif
            if (state == POP_FL) fl_l <= bus.dtr;
            if (state == POP_PC) pc_l <= bus.dtr;
          end
`ifdef HS32_IRQ_SEQ_TIMEOUT_EN
          else if (tmo == 4'd14) begin
            // Fifteenth unacknowledged strobe cycle: abandon the sequence untouched.
            tmo   <= 4'd15;
            stb   <= 1'b0;
            fault <= 1'b1;
            state <= IDLE;
          end else begin
            tmo <= tmo + 4'd1;
          end
`endif
        end

        JUMP:    state <= IDLE;
        RET:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
